// File: rtl/aes_pkg.sv
// Shared AES types and the byte-substitution functions used by sub_bytes_engine.
// The S-box is computed (GF(2^8) inverse plus affine map) rather than tabulated.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W = 128;
  localparam int unsigned AES_NBYTES  = 16;

  typedef logic [7:0] aes_byte_t;
  typedef aes_byte_t [AES_NBYTES-1:0] aes_state_t;

  typedef enum logic [1:0] {SB_IDLE, SB_BUSY, SB_DONE} sb_state_e;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic aes_byte_t gf_mul(aes_byte_t a, aes_byte_t b);
    aes_byte_t p = '0;
    aes_byte_t x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0.
  function automatic aes_byte_t gf_inv(aes_byte_t a);
    aes_byte_t sq = a;
    aes_byte_t r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic aes_byte_t rotl8(aes_byte_t x, int unsigned n);
    aes_byte_t r = x;
    for (int unsigned i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic aes_byte_t s_box(aes_byte_t b);
    aes_byte_t v = gf_inv(b);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic aes_byte_t inv_s_box(aes_byte_t b);
    return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// One substitution lane: a single byte through the forward S-box, or through the
// inverse S-box when AES_INV_SBOX_EN is defined and inv_i is set.
module sbox_lane
  import aes_pkg::*;
(
  input  aes_byte_t byte_i,
`ifdef AES_INV_SBOX_EN
  input  logic      inv_i,
`endif
  output aes_byte_t byte_o
);

  // Purely combinational substitution of the selected byte.
  always_comb begin
`ifdef AES_INV_SBOX_EN
    byte_o = inv_i ? inv_s_box(byte_i) : s_box(byte_i);
`else
    byte_o = s_box(byte_i);
`endif
  end

endmodule

// File: rtl/sub_bytes_engine.sv
// Handshaked AES SubBytes stage: LANES S-boxes process the 16-byte state over
// 16/LANES beats, and the result is held until downstream accepts it.
// Optional macro AES_INV_SBOX_EN adds the in_inv port and inverse S-boxes.
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int unsigned LANES   = 16,
  parameter int unsigned OUT_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
`ifdef AES_INV_SBOX_EN
  input  logic                   in_inv,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic                   busy
);

  localparam int unsigned NBEATS = AES_NBYTES / LANES;
  localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  if (!(LANES inside {1, 2, 4, 8, 16})) begin : g_bad_lanes
    $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end
  if (OUT_REG != 1) begin : g_bad_out_reg
    $error("sub_bytes_engine: OUT_REG=0 is reserved");
  end

  sb_state_e         state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  aes_state_t        data_q, data_d;
  aes_state_t        res_q, res_d;
  logic              inv_q, inv_d;
  logic              accept;

  aes_byte_t [LANES-1:0] lane_in;
  aes_byte_t [LANES-1:0] lane_out;

  // Lane i sees byte beat*LANES+i of the latched input state.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_in[i] = data_q[4'(32'(beat_q) * LANES + 32'(i))];
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sbox_lane u_lane (
      .byte_i (lane_in[i]),
`ifdef AES_INV_SBOX_EN
      .inv_i  (inv_q),
`endif
      .byte_o (lane_out[i])
    );
  end

  // Next-state: handshake decode, beat sequencing and result write-back.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    data_d   = data_q;
    res_d    = res_q;
    inv_d    = inv_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    unique case (state_q)
      SB_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      SB_BUSY: begin
        for (int i = 0; i < LANES; i++) begin
          res_d[4'(32'(beat_q) * LANES + 32'(i))] = lane_out[i];
        end
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = SB_DONE;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      SB_DONE: begin
        // A new state is only taken when the held result leaves the same cycle.
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) accept = 1'b1;
          else          state_d = SB_IDLE;
        end
      end
      default: state_d = SB_IDLE;
    endcase
    if (accept) begin
      data_d  = in_data;
`ifdef AES_INV_SBOX_EN
      inv_d   = in_inv;
`else
      inv_d   = 1'b0;
`endif
      beat_d  = '0;
      state_d = SB_BUSY;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SB_IDLE;
      beat_q  <= '0;
      data_q  <= '0;
      res_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      res_q   <= res_d;
      inv_q   <= inv_d;
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    out_valid = (state_q == SB_DONE);
    busy      = (state_q == SB_BUSY);
    out_data  = res_q;
  end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Self-checking bench for sub_bytes_engine (LANES=4). Expected results come from
// known S-box constants and are queued on acceptance, then compared on output.
module tb_sub_bytes_engine;

  localparam int unsigned LANES  = 4;
  localparam int unsigned NBEATS = 16 / LANES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  always #5 clk = ~clk;

  sub_bytes_engine #(
    .LANES   (LANES),
    .OUT_REG (1)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef AES_INV_SBOX_EN
    .in_inv    (in_inv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // S-box rows 0x00..0x0f and 0x10..0x1f, byte j at [8*j +: 8].
  logic [127:0] row0 = 128'h76abd7fe2b670130c56f6bf27b777c63;
  logic [127:0] row1 = 128'hc072a49cafa2d4adf04759fa7dc982ca;
  logic [127:0] vin0 = 128'h0f0e0d0c0b0a09080706050403020100;
  logic [127:0] vin1 = 128'h1f1e1d1c1b1a19181716151413121110;

  logic [127:0] exp_q[$];
  logic [127:0] mon_exp;
  int unsigned  n_cmp = 0;
  int unsigned  n_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: a result transfers at the posedge after a negedge with valid & ready.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out", {127'd0, out_valid}, 128'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("out_data", out_data, mon_exp);
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic [127:0] e, output logic was_done);
    logic taken;
    taken    = 1'b0;
    was_done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 200 && !taken; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        was_done = out_valid;
        taken    = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    if (!taken) check_eq("accept_timeout", {127'd0, in_ready}, 128'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    check_eq("drain", 128'(exp_q.size()), 128'd0);
  endtask

  logic [127:0] rin, rexp;
  logic         wd;
  int unsigned  lat, busy_cnt;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_inv    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check_eq("rst_out_data", out_data, 128'd0);
    check_eq("rst_in_ready", {127'd0, in_ready}, 128'd1);
    check_eq("rst_busy", {127'd0, busy}, 128'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // FIPS-197 round-1 vector; measure latency and busy duration.
    send(128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230, wd);
    lat      = 0;
    busy_cnt = 0;
    for (int k = 0; k < 64 && !out_valid; k++) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("latency", 128'(lat), 128'(NBEATS));
    check_eq("busy_cycles", 128'(busy_cnt), 128'(NBEATS));
    drain();

    // Back-to-back: second state taken in DONE, straight into BUSY.
    send(vin0, row0, wd);
    send({16{8'h53}}, {16{8'hed}}, wd);
    check_eq("b2b_taken_in_done", {127'd0, wd}, 128'd1);
    check_eq("b2b_busy_next", {127'd0, busy}, 128'd1);
    drain();

    // Stall: result held, in_ready low, new in_valid ignored.
    out_ready = 1'b0;
    send({16{8'h00}}, {16{8'h63}}, wd);
    for (int t = 0; t < 50 && !out_valid; t++) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = {16{8'hff}};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_in_ready", {127'd0, in_ready}, 128'd0);
      check_eq("stall_out_valid", {127'd0, out_valid}, 128'd1);
      check_eq("stall_out_data", out_data, {16{8'h63}});
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("stall_release_valid", {127'd0, out_valid}, 128'd0);
    check_eq("stall_release_busy", {127'd0, busy}, 128'd0);
    drain();

    // Reset mid-BUSY discards the in-flight state.
    send(vin1, row1, wd);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    check_eq("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    check_eq("midrst_out_data", out_data, 128'd0);
    check_eq("midrst_in_ready", {127'd0, in_ready}, 128'd1);
    check_eq("midrst_busy", {127'd0, busy}, 128'd0);
    rst_n = 1'b1;
    send(vin1, row1, wd);
    drain();

    // Random states built from the known 32-entry slice of the S-box.
    for (int v = 0; v < 8; v++) begin
      for (int j = 0; j < 16; j++) begin
        int unsigned idx;
        idx            = $urandom_range(0, 31);
        rin[8*j +: 8]  = 8'(idx);
        rexp[8*j +: 8] = (idx < 16) ? row0[8*idx +: 8] : row1[8*(idx-16) +: 8];
      end
      send(rin, rexp, wd);
    end
    drain();

`ifdef AES_INV_SBOX_EN
    in_inv = 1'b1;
    send({16{8'h63}}, {16{8'h00}}, wd);
    send({16{8'hed}}, {16{8'h53}}, wd);
    in_inv = 1'b0;
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
